len_hdr_check: RTL and testbench
================================

# len_hdr_check

Length-header checker on the transmit path of an I/O queue, upstream of the header-removal stage. Consumes the packet-length module header that the receive-side header inserter prepends (bytes in [15:0], source port in [31:16], words in [47:32]). Independently counts the words and bytes that actually follow it and compares the two. Every word passes through unmodified with one register stage; each packet's verdict is reported as a per-packet pulse and in saturating good/bad counters.

## Interface
- DATA_WIDTH, 64, data bus width; only 64 is supported.
- CTRL_WIDTH, DATA_WIDTH/8, control bus width.
- STAGE_NUMBER, 'hff, ctrl value that identifies the length header word.
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  DATA_WIDTH  upstream word.
- in_ctrl  in  CTRL_WIDTH  upstream ctrl.
- in_wr  in  1  upstream word valid.
- in_rdy  out  1  block can accept a word.
- out_data  out  DATA_WIDTH  registered copy of in_data.
- out_ctrl  out  CTRL_WIDTH  registered copy of in_ctrl.
- out_wr  out  1  registered copy of the accept strobe.
- out_rdy  in  1  downstream can accept a word.
- chk_done  out  1  one-cycle pulse marking a packet verdict.
- chk_err  out  1  valid with chk_done; 1 = mismatch.
- good_count  out  32  saturating count of passing packets.
- bad_count  out  32  saturating count of failing packets.

## Operation
- in_rdy = out_rdy (combinational).
- A word is accepted when in_wr is high; upstream asserts in_wr only while in_rdy is high.
- The out_rdy source guarantees room for at least one word after it deasserts.
- Packet format: one or more module-header words (ctrl != 0), then data words with ctrl == 0, then a last word with one-hot ctrl.
  - Ctrl bit k set means 8−k valid bytes: 0x01 = 8 bytes, 0x80 = 1 byte.
  - A packet has at least 2 data words.
- FSM state HDR (reset state):
  - Accepted word with ctrl == STAGE_NUMBER: latch hdr_bytes = data[15:0] and hdr_words = data[47:32]; set hdr_seen. If several such words arrive, the last one wins.
  - Other ctrl != 0 words are passed through and ignored.
  - First accepted ctrl == 0 word: word_cnt = 1, go to DATA.
- FSM state DATA:
  - Accepted ctrl == 0 word: word_cnt += 1.
  - Accepted ctrl != 0 word is the last word:
    - words = word_cnt + 1.
    - bytes = word_cnt·8 + valid(ctrl), computed in 16 bits.
  - err = !hdr_seen, OR ctrl not one-hot, OR words != hdr_words, OR bytes != hdr_bytes.
  - Issue the verdict, clear hdr_seen, return to HDR.
- Internal word_cnt is 16 bits and saturates at 'hffff; a saturated count always yields err = 1.
- Verdict:
  - chk_done = 1 for exactly one cycle; chk_err = err.
  - If err, bad_count += 1; otherwise good_count += 1.
  - Both counters saturate at 'hffffffff.
- Data and ctrl are never altered. Failing packets are still forwarded.

## Timing
- Latency is 1 cycle: a word accepted in cycle t appears on out_* with out_wr = 1 in cycle t+1.
- out_wr = 0 in every cycle after a cycle with no accept.
- chk_done/chk_err are asserted in the same cycle the last word appears on out_* (t+1).
- Counters show the updated value in that same cycle t+1.
- chk_err = 0 whenever chk_done = 0.
- Back-to-back packets with no idle cycle are supported. The verdict of packet N and the header latch of packet N+1 happen in consecutive cycles without interference.
- Reset values: out_data = 0, out_ctrl = 0, out_wr = 0, chk_done = 0, chk_err = 0, good_count = 0, bad_count = 0; FSM = HDR, hdr_seen = 0, word_cnt = 0.
- Reset mid-packet abandons the packet: no verdict and no counter change. Words after reset are parsed from HDR.
- in_wr during reset is ignored.

## Test plan
- Good 60-byte packet: header ctrl 'hff with bytes 60, words 8; then 7 words with ctrl 0 and a last word with ctrl 0x10. Required: 9 words out unchanged, each 1 cycle after input; chk_done with chk_err = 0 on the last word's out cycle; good_count = 1.
- Byte mismatch: same packet but header bytes = 61. Required: chk_err = 1, bad_count = 1, good_count unchanged, all words forwarded.
- Missing header: only a ctrl 'hab module header, then 8 data words with last ctrl 0x01. Required: chk_err = 1.
- Non-one-hot last ctrl 0x30 with a matching header. Required: chk_err = 1.
- Back-to-back: one good and one word-mismatch (header words 9, 8 sent) packet with no gap, with out_rdy toggled low for 3 cycles mid-packet and in_wr held off while in_rdy is low. Required: verdicts 0 then 1; good_count = 1, bad_count = 1; no word lost or duplicated.
- Reset asserted after the 4th data word, then a good packet is sent. Required: no verdict for the first packet; outputs zero during reset; second packet gives chk_err = 0, good_count = 1, bad_count = 0.

Source files
------------

// File: rtl/len_hdr_check_if.sv
// Word-stream bus used on both sides of the length-header checker.
// The master drives data/ctrl/wr and samples rdy; the slave does the reverse.
interface len_hdr_check_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] data;
   logic [CTRL_WIDTH-1:0] ctrl;
   logic                  wr;
   logic                  rdy;

   modport master (output data, output ctrl, output wr, input rdy);
   modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/len_hdr_check.sv
// Length-header checker: forwards every word with one register stage and,
// per packet, compares the length module header against the words/bytes
// actually seen, reporting a one-cycle verdict and saturating counters.
module len_hdr_check #(
   parameter int                   DATA_WIDTH   = 64,
   parameter int                   CTRL_WIDTH   = DATA_WIDTH / 8,
   parameter logic [CTRL_WIDTH-1:0] STAGE_NUMBER = 'hff
) (
   input  logic                clk,
   input  logic                reset,
   len_hdr_check_if.slave      in_if,
   len_hdr_check_if.master     out_if,
   output logic                chk_done,
   output logic                chk_err,
   output logic [31:0]         good_count,
   output logic [31:0]         bad_count
);

   typedef enum logic {HDR, DATA} state_t;

   state_t                state_q, state_d;
   logic                  hdr_seen_q, hdr_seen_d;
   logic [15:0]           hdr_bytes_q, hdr_bytes_d;
   logic [15:0]           hdr_words_q, hdr_words_d;
   logic [15:0]           word_cnt_q, word_cnt_d;

   logic [DATA_WIDTH-1:0] out_data_q;
   logic [CTRL_WIDTH-1:0] out_ctrl_q;
   logic                  out_wr_q;
   logic                  chk_done_q, chk_err_q;
   logic [31:0]           good_count_q, bad_count_q;

   logic                  verdict_d, err_d;
   logic                  accept;
   logic                  ctrl_zero, ctrl_onehot, cnt_sat;
   logic [3:0]            lane_val [CTRL_WIDTH];
   logic [3:0]            last_valid;
   logic [15:0]           seen_words, seen_bytes;

   // Backpressure is passed straight through; the downstream guarantees a
   // one-word cushion so the pipeline register never needs to hold.
   assign in_if.rdy = out_if.rdy;
   assign accept    = in_if.wr;

   assign out_if.data = out_data_q;
   assign out_if.ctrl = out_ctrl_q;
   assign out_if.wr   = out_wr_q;
   assign chk_done    = chk_done_q;
   assign chk_err     = chk_err_q;
   assign good_count  = good_count_q;
   assign bad_count   = bad_count_q;

   // Ctrl bit k of the last word means 8-k valid bytes.
   genvar gi;
   generate
      for (gi = 0; gi < CTRL_WIDTH; gi++) begin : g_lane
         assign lane_val[gi] = in_if.ctrl[gi] ? 4'(CTRL_WIDTH - gi) : 4'd0;
      end
   endgenerate

   // Fold per-lane byte counts; only meaningful for a one-hot ctrl, and any
   // other ctrl is flagged as an error independently.
   always_comb begin
      last_valid = 4'd0;
      for (int k = 0; k < CTRL_WIDTH; k++) begin
         last_valid = last_valid | lane_val[k];
      end
   end

   assign ctrl_zero   = (in_if.ctrl == '0);
   assign ctrl_onehot = !ctrl_zero && ((in_if.ctrl & (in_if.ctrl - 1'b1)) == '0);
   assign cnt_sat     = (word_cnt_q == 16'hffff);
   assign seen_words  = word_cnt_q + 16'd1;
   assign seen_bytes  = {word_cnt_q[12:0], 3'b000} + {12'd0, last_valid};

   // Packet parser: latch the length header, count data words, judge the last word.
   always_comb begin
      state_d     = state_q;
      hdr_seen_d  = hdr_seen_q;
      hdr_bytes_d = hdr_bytes_q;
      hdr_words_d = hdr_words_q;
      word_cnt_d  = word_cnt_q;
      verdict_d   = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         HDR: begin
            if (accept) begin
               if (!ctrl_zero) begin
                  if (in_if.ctrl == STAGE_NUMBER) begin
                     hdr_bytes_d = in_if.data[15:0];
                     hdr_words_d = in_if.data[47:32];
                     hdr_seen_d  = 1'b1;
                  end
               end else begin
                  word_cnt_d = 16'd1;
                  state_d    = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               if (ctrl_zero) begin
                  if (!cnt_sat) begin
                     word_cnt_d = word_cnt_q + 16'd1;
                  end
               end else begin
                  verdict_d  = 1'b1;
                  err_d      = !hdr_seen_q || !ctrl_onehot || cnt_sat ||
                               (seen_words != hdr_words_q) ||
                               (seen_bytes != hdr_bytes_q);
                  hdr_seen_d = 1'b0;
                  word_cnt_d = 16'd0;
                  state_d    = HDR;
               end
            end
         end
         default: state_d = HDR;
      endcase
   end

   // Parser state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= HDR;
         hdr_seen_q  <= 1'b0;
         hdr_bytes_q <= 16'd0;
         hdr_words_q <= 16'd0;
         word_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         hdr_seen_q  <= hdr_seen_d;
         hdr_bytes_q <= hdr_bytes_d;
         hdr_words_q <= hdr_words_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   // One-stage pass-through of the word stream, unmodified.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q <= '0;
         out_ctrl_q <= '0;
         out_wr_q   <= 1'b0;
      end else begin
         out_data_q <= in_if.data;
         out_ctrl_q <= in_if.ctrl;
         out_wr_q   <= accept;
      end
   end

   // Verdict pulse and saturating pass/fail counters, aligned with the last word out.
   always_ff @(posedge clk) begin
      if (reset) begin
         chk_done_q   <= 1'b0;
         chk_err_q    <= 1'b0;
         good_count_q <= 32'd0;
         bad_count_q  <= 32'd0;
      end else begin
         chk_done_q <= verdict_d;
         chk_err_q  <= verdict_d && err_d;
         if (verdict_d && err_d && (bad_count_q != 32'hffff_ffff)) begin
            bad_count_q <= bad_count_q + 32'd1;
         end
         if (verdict_d && !err_d && (good_count_q != 32'hffff_ffff)) begin
            good_count_q <= good_count_q + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_len_hdr_check.sv
// Scoreboard bench for len_hdr_check: the driver queues each expected output
// word (with its verdict where applicable); a negedge monitor pops and compares.
module tb_len_hdr_check;

   logic        clk = 1'b0;
   logic        reset;
   logic        chk_done, chk_err;
   logic [31:0] good_count, bad_count;

   always #5 clk = ~clk;

   len_hdr_check_if #(.DATA_WIDTH(64)) in_if ();
   len_hdr_check_if #(.DATA_WIDTH(64)) out_if ();

   len_hdr_check #(.DATA_WIDTH(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_if      (in_if),
      .out_if     (out_if),
      .chk_done   (chk_done),
      .chk_err    (chk_err),
      .good_count (good_count),
      .bad_count  (bad_count)
   );

   typedef struct {
      logic [63:0] data;
      logic [7:0]  ctrl;
      int          cyc;
      bit          done;
      bit          err;
      int unsigned good;
      int unsigned bad;
   } exp_t;

   exp_t        sb[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          cyc = 0;
   int unsigned exp_good = 0;
   int unsigned exp_bad = 0;
   bit          mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Monitor: every presented word must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (out_if.wr) begin
            if (sb.size() == 0) begin
               check("unexpected_word", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("out_data", out_if.data, e.data);
               check("out_ctrl", {56'd0, out_if.ctrl}, {56'd0, e.ctrl});
               check("latency_cycle", 64'(cyc), 64'(e.cyc));
               check("chk_done", {63'd0, chk_done}, {63'd0, e.done});
               if (e.done) begin
                  check("chk_err", {63'd0, chk_err}, {63'd0, e.err});
                  check("good_count", {32'd0, good_count}, {32'd0, e.good});
                  check("bad_count", {32'd0, bad_count}, {32'd0, e.bad});
                  $display("verdict: data=%h ctrl=%h err=%0b good=%0d bad=%0d",
                           out_if.data, out_if.ctrl, chk_err, good_count, bad_count);
               end else begin
                  check("chk_err_no_done", {63'd0, chk_err}, 64'd0);
                  $display("word: data=%h ctrl=%h", out_if.data, out_if.ctrl);
               end
            end
         end else begin
            check("idle_verdict", {62'd0, chk_done, chk_err}, 64'd0);
         end
      end
   end

   // Present one word, waiting (bounded) for in_rdy, and queue its expectation.
   task automatic drive(input logic [63:0] d, input logic [7:0] c, input bit done, input bit err);
      int w = 0;
      while (!in_if.rdy) begin
         if (w >= 100) begin
            check("rdy_timeout", 64'd0, 64'd1);
            break;
         end
         @(posedge clk); #1;
         w++;
      end
      in_if.data = d;
      in_if.ctrl = c;
      in_if.wr   = 1'b1;
      if (done) begin
         if (err) exp_bad++;
         else     exp_good++;
      end
      sb.push_back('{d, c, cyc + 1, done, err, exp_good, exp_bad});
      @(posedge clk); #1;
      in_if.wr = 1'b0;
   endtask

   // Pull out_rdy low for three cycles; in_rdy must follow it.
   task automatic stall();
      out_if.rdy = 1'b0;
      repeat (3) begin
         #1 check("in_rdy_low", {63'd0, in_if.rdy}, 64'd0);
         @(posedge clk); #1;
      end
      out_if.rdy = 1'b1;
      #1 check("in_rdy_high", {63'd0, in_if.rdy}, 64'd1);
   endtask

   // Packet: 'hab module header, optional length header, ndata ctrl-0 words, last word.
   task automatic send_pkt(input bit stage, input logic [15:0] bytes, input logic [15:0] words,
                           input int ndata, input logic [7:0] last, input bit err,
                           input int stall_at, input logic [7:0] id);
      drive({16'h0, 16'h1234, 16'h0003, 8'h55, id}, 8'hab, 1'b0, 1'b0);
      if (stage) drive({16'h0, words, 16'h0003, bytes}, 8'hff, 1'b0, 1'b0);
      for (int i = 0; i < ndata; i++) begin
         if (i == stall_at) stall();
         drive({8'hd0, id, 32'h0, 16'(i)}, 8'h00, 1'b0, 1'b0);
      end
      drive({8'he0, id, 48'h0000_cafe_0000}, last, 1'b1, err);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      in_if.data = '0;
      in_if.ctrl = '0;
      in_if.wr   = 1'b0;
      out_if.rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_wr", {63'd0, out_if.wr}, 64'd0);
      check("rst_out_data", out_if.data, 64'd0);
      check("rst_out_ctrl", {56'd0, out_if.ctrl}, 64'd0);
      check("rst_chk_done", {63'd0, chk_done}, 64'd0);
      check("rst_chk_err", {63'd0, chk_err}, 64'd0);
      check("rst_good", {32'd0, good_count}, 64'd0);
      check("rst_bad", {32'd0, bad_count}, 64'd0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Good 60-byte packet: 7*8 + 4 = 60 bytes, 8 words.
      send_pkt(1'b1, 16'd60, 16'd8, 7, 8'h10, 1'b0, -1, 8'h01);
      // Byte mismatch: header claims 61.
      send_pkt(1'b1, 16'd61, 16'd8, 7, 8'h10, 1'b1, -1, 8'h02);
      // Missing length header: 8 data words, last ctrl 0x01.
      send_pkt(1'b0, 16'd64, 16'd8, 7, 8'h01, 1'b1, -1, 8'h03);
      // Non-one-hot last ctrl.
      send_pkt(1'b1, 16'd60, 16'd8, 7, 8'h30, 1'b1, -1, 8'h04);
      // Back-to-back: good with mid-packet stall, then a word-count mismatch.
      send_pkt(1'b1, 16'd60, 16'd8, 7, 8'h10, 1'b0, 3, 8'h05);
      send_pkt(1'b1, 16'd60, 16'd9, 7, 8'h10, 1'b1, -1, 8'h06);

      // Reset after the 4th data word of a packet; a stray in_wr during reset.
      drive({16'h0, 16'h1234, 16'h0003, 16'h0007}, 8'hab, 1'b0, 1'b0);
      drive({16'h0, 16'd8, 16'h0003, 16'd60}, 8'hff, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive({8'hd0, 8'h07, 32'h0, 16'(i)}, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      @(posedge clk); #1;
      reset      = 1'b1;
      in_if.data = 64'hbad0_bad0_bad0_bad0;
      in_if.ctrl = 8'h00;
      in_if.wr   = 1'b1;
      @(posedge clk); #1;
      in_if.wr = 1'b0;
      @(posedge clk); #1;
      check("midrst_out_wr", {63'd0, out_if.wr}, 64'd0);
      check("midrst_out_data", out_if.data, 64'd0);
      check("midrst_chk_done", {63'd0, chk_done}, 64'd0);
      check("midrst_good", {32'd0, good_count}, 64'd0);
      check("midrst_bad", {32'd0, bad_count}, 64'd0);
      exp_good = 0;
      exp_bad  = 0;
      reset    = 1'b0;
      send_pkt(1'b1, 16'd60, 16'd8, 7, 8'h10, 1'b0, -1, 8'h08);

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      check("final_good", {32'd0, good_count}, 64'd1);
      check("final_bad", {32'd0, bad_count}, 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
